mux_5_to_1_collector: RTL and testbench
=======================================

Name: mux_5_to_1_collector

Overview:
- Reverse direction of the 1-to-5 demux: merges five parallel lanes (e.g. five convolution-unit result streams) into one registered output stream.
- Each output word is tagged with a 3-bit source select. The encoding matches the demux: lane k has sel = k-1, so lane 1 = 3'b000 and lane 5 = 3'b100.
- Each lane has a one-entry holding buffer. Lanes are served round-robin, and the output uses a valid/ready handshake.
- Sits between the parallel compute units and the single-port writeback/next-layer path.

Parameters:
- DATA_WIDTH, 16, width of each lane word and of dout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- din  input  5*DATA_WIDTH  lane words; lane k occupies bits [k*DATA_WIDTH-1 : (k-1)*DATA_WIDTH], k = 1..5.
- din_valid  input  5  per-lane valid; bit k-1 belongs to lane k.
- din_ready  output  5  per-lane ready; bit k-1 belongs to lane k.
- dout  output  DATA_WIDTH  selected word, registered.
- dout_sel  output  3  source lane of dout; values 0..4 only, registered.
- dout_valid  output  1  dout and dout_sel hold a word.
- dout_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (reset==0 at a clock edge):
  - all five lane buffers empty; dout_valid=0, dout=0, dout_sel=0; round-robin pointer ptr=0.
  - din_ready=5'b00000 while reset is low.
  - Asserting reset mid-transfer discards every buffered word and the output word; nothing is flushed.
- Lane acceptance:
  - din_ready[i] = ~buf_v[i], driven combinationally from the buffer-full flag only.
  - A word transfers when din_valid[i] && din_ready[i] at the edge; buf_v[i] becomes 1 and the word is captured.
  - A lane can therefore accept at most one word every 2 cycles. The same lane is never refilled in the cycle it is drained.
- Output load:
  - load = ~dout_valid | dout_ready.
  - When load is true and any buf_v is set, the arbiter grants the first full buffer found scanning ptr, ptr+1, … modulo 5.
  - At that edge: dout <= buffer data; dout_sel <= granted index; dout_valid <= 1; buf_v[granted] <= 0; ptr <= (granted+1) mod 5.
  - When load is true and no buffer is full, dout_valid <= 0 and dout/dout_sel hold their previous values.
  - When load is false (dout_valid && !dout_ready), all output state holds and no buffer is drained.
- Latency: a word accepted at edge N appears with dout_valid=1 after edge N+1, provided the output is free and no higher-priority buffer is full.
- Throughput: one word per cycle at the output when dout_ready is held high and at least one buffer is full.
- Fairness: with all five lanes continuously full and dout_ready=1, dout_sel cycles 0,1,2,3,4,0,… Any lane is served within 5 output transfers of becoming full.
- ptr is only ever 0..4; wrap from 4 goes to 0. dout_sel is never 5..7.
- Simultaneous events:
  - Acceptance on a lane and a grant on a different lane in the same cycle are independent.
  - Grant and output handshake in the same cycle give back-to-back transfer with no bubble.

Optional Feature:
- Macro: COLLECTOR_STRICT_ORDER_EN.
- Defined: the arbiter grants only lane ptr. If buf_v[ptr]==0 while load is true, no grant occurs and dout_valid <= 0.
  - The output order is exactly 0,1,2,3,4 repeating, for re-interleaving the demux's sequential split.
  - ptr advances only on a grant.
- Undefined: work-conserving round-robin as specified above.

Test Plan:
- Reset release, idle inputs -> din_ready=5'b11111 on the first cycle after reset goes high; dout_valid=0, dout=0, dout_sel=0.
- Single word 16'h00A5 on lane 3 at edge N, dout_ready=1 -> dout=16'h00A5, dout_sel=3'd2, dout_valid=1 after edge N+1; din_ready[2]=0 for exactly one cycle.
- All lanes hold words 16'h1001..16'h1005 in the same cycle, dout_ready=1:
  - outputs 16'h1001..16'h1005 on 5 consecutive cycles with dout_sel 0,1,2,3,4.
  - then reload lane 1 only -> dout_sel=0 again, with ptr having wrapped.
- Backpressure: dout_ready=0 for 4 cycles with lane 2 and lane 5 full -> dout and dout_sel stay stable; buf_v stays set.
  - After dout_ready=1, words follow in round-robin order with no loss or duplication.
- Reset pulled low for one cycle while 3 buffers are full and dout_valid=1 -> all cleared; no stale word appears on dout afterwards.
- COLLECTOR_STRICT_ORDER_EN defined, lane 2 filled before lane 1 -> no output until lane 1 is filled; then dout_sel=0 followed by dout_sel=1.

Source files
------------

// File: rtl/mux_5_to_1_collector_if.sv
// Lane-side and output-side signals of the 5-to-1 collector.
// The slave modport is the collector's view; master is the surrounding fabric.
interface mux_5_to_1_collector_if #(
    parameter int DATA_WIDTH = 16
);
    logic [5*DATA_WIDTH-1:0] din;
    logic [4:0]              din_valid;
    logic [4:0]              din_ready;
    logic [DATA_WIDTH-1:0]   dout;
    logic [2:0]              dout_sel;
    logic                    dout_valid;
    logic                    dout_ready;

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_sel, dout_valid
    );

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_sel, dout_valid
    );
endinterface

// File: rtl/mux_5_to_1_collector.sv
// Merges five lanes, each with a one-entry buffer, into one registered stream tagged with its lane.
// Define COLLECTOR_STRICT_ORDER_EN to grant only lane ptr (fixed 0..4 order) instead of work-conserving round-robin.
module mux_5_to_1_collector #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mux_5_to_1_collector_if.slave bus
);
    logic [DATA_WIDTH-1:0] buf_d [5];
    logic [4:0]            buf_v;
    logic [2:0]            ptr;

    logic [DATA_WIDTH-1:0] out_data;
    logic [2:0]            out_sel;
    logic                  out_valid;

    logic                  load;
    logic                  grant;
    logic [2:0]            gnt_idx;
    logic [2:0]            next_ptr;
    logic [4:0]            accept;

    // Modulo-5 wrap for a value in 0..9; keeps ptr and dout_sel inside 0..4.
    function automatic logic [2:0] wrap5(input logic [3:0] v);
        logic [3:0] s;
        s = (v >= 4'd5) ? v - 4'd5 : v;
        return s[2:0];
    endfunction

    assign bus.din_ready  = reset ? ~buf_v : 5'b00000;
    assign bus.dout       = out_data;
    assign bus.dout_sel   = out_sel;
    assign bus.dout_valid = out_valid;

    assign load   = ~out_valid | bus.dout_ready;
    assign accept = bus.din_valid & ~buf_v;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = ptr;
`ifdef COLLECTOR_STRICT_ORDER_EN
        grant = load & buf_v[ptr];
`else
        // Scan from the far end back to ptr so the nearest full buffer wins.
        for (int off = 4; off >= 0; off--) begin
            logic [2:0] idx;
            idx = wrap5({1'b0, ptr} + 4'(off));
            if (buf_v[idx]) begin
                grant   = load;
                gnt_idx = idx;
            end
        end
`endif
        next_ptr = wrap5({1'b0, gnt_idx} + 4'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_v     <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            // A lane is never drained and refilled in one cycle: accept needs buf_v=0, grant needs buf_v=1.
            for (int i = 0; i < 5; i++) begin
                if (grant && gnt_idx == 3'(i))
                    buf_v[i] <= 1'b0;
                else if (accept[i])
                    buf_v[i] <= 1'b1;
            end
            if (load) begin
                out_valid <= grant;
                if (grant) begin
                    out_data <= buf_d[gnt_idx];
                    out_sel  <= gnt_idx;
                    ptr      <= next_ptr;
                end
            end
        end
    end

    // NOTE: lane data storage is not reset; buf_v alone decides whether a word is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (reset && accept[i])
                buf_d[i] <= bus.din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_mux_5_to_1_collector.sv
// Randomized and directed bench for mux_5_to_1_collector against a lane-array reference model.
// Follows COLLECTOR_STRICT_ORDER_EN when the build defines it.
module tb_mux_5_to_1_collector;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_5_to_1_collector_if #(.DATA_WIDTH(DW)) bus ();

    mux_5_to_1_collector #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what each lane holds and what the output register holds after the coming edge.
    bit            m_full [5];
    logic [DW-1:0] m_word [5];
    int            m_ptr;
    bit            m_ov;
    logic [DW-1:0] m_od;
    int            m_os;

    int accepted = 0;
    int delivered = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model_ready();
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = reset & ~m_full[i];
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic [4:0] vld,
                              input logic [5*DW-1:0] words, input logic rdy);
        bit take [5];
        int pick;
        if (!rst) begin
            for (int i = 0; i < 5; i++) m_full[i] = 0;
            m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0;
            accepted = 0; delivered = 0;
            return;
        end
        if (m_ov && rdy) delivered++;
        for (int i = 0; i < 5; i++) take[i] = vld[i] && !m_full[i];
        pick = -1;
        if (!m_ov || rdy) begin
`ifdef COLLECTOR_STRICT_ORDER_EN
            if (m_full[m_ptr]) pick = m_ptr;
`else
            for (int off = 0; off < 5 && pick < 0; off++)
                if (m_full[(m_ptr + off) % 5]) pick = (m_ptr + off) % 5;
`endif
            m_ov = (pick >= 0);
            if (pick >= 0) begin
                m_od = m_word[pick];
                m_os = pick;
                m_full[pick] = 0;
                m_ptr = (pick + 1) % 5;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (take[i]) begin
                m_full[i] = 1;
                m_word[i] = words[i*DW +: DW];
                accepted++;
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare 1 time unit after the edge.
    task automatic cycle(input logic rst, input logic [4:0] vld,
                         input logic [5*DW-1:0] words, input logic rdy);
        reset          = rst;
        bus.din_valid  = vld;
        bus.din        = words;
        bus.dout_ready = rdy;
        model_step(rst, vld, words, rdy);
        @(posedge clk);
        #1;
        check("din_ready", 32'(bus.din_ready), 32'(model_ready()));
        check("dout_valid", 32'(bus.dout_valid), 32'(m_ov));
        check("dout", 32'(bus.dout), 32'(m_od));
        check("dout_sel", 32'(bus.dout_sel), 32'(m_os));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) cycle(1'b1, 5'b0, '0, rdy);
    endtask

    function automatic logic [5*DW-1:0] lane_word(input int lane, input logic [DW-1:0] w);
        logic [5*DW-1:0] v;
        v = '0;
        v[(lane-1)*DW +: DW] = w;
        return v;
    endfunction

    initial begin
        logic [5*DW-1:0] all_words;
        int pending;

        reset = 1'b0; bus.din = '0; bus.din_valid = '0; bus.dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) cycle(1'b0, 5'b0, '0, 1'b0);
        check("ready_in_reset", 32'(bus.din_ready), 32'h0);
        idle(1, 1'b0);
        check("ready_after_reset", 32'(bus.din_ready), 32'h1f);
        check("dout_reset", 32'(bus.dout), 32'h0);

`ifndef COLLECTOR_STRICT_ORDER_EN
        // Single word on lane 3.
        cycle(1'b1, 5'b00100, lane_word(3, 16'h00A5), 1'b1);
        check("lane3_busy", 32'(bus.din_ready[2]), 32'h0);
        idle(1, 1'b1);
        check("single_dout", 32'(bus.dout), 32'h00A5);
        check("single_sel", 32'(bus.dout_sel), 32'd2);
        check("lane3_free", 32'(bus.din_ready[2]), 32'h1);
`endif

        // All five lanes loaded together.
        cycle(1'b0, 5'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) all_words[i*DW +: DW] = 16'h1001 + 16'(i);
        cycle(1'b1, 5'b11111, all_words, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle(1, 1'b1);
            check("rr_sel", 32'(bus.dout_sel), 32'(i));
            check("rr_word", 32'(bus.dout), 32'h1001 + 32'(i));
        end
        cycle(1'b1, 5'b00001, lane_word(1, 16'h2222), 1'b1);
        idle(1, 1'b1);
        check("wrap_sel", 32'(bus.dout_sel), 32'd0);

        // Backpressure with lanes 2 and 5 full.
        cycle(1'b0, 5'b0, '0, 1'b0);
        cycle(1'b1, 5'b10010, lane_word(2, 16'hB002) | lane_word(5, 16'hB005), 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle(1, 1'b0);
`ifndef COLLECTOR_STRICT_ORDER_EN
            check("bp_sel_stable", 32'(bus.dout_sel), 32'd1);
            check("bp_lane5_held", 32'(bus.din_ready[4]), 32'h0);
`endif
        end
        idle(4, 1'b1);

        // Reset while three buffers and the output are occupied.
        cycle(1'b1, 5'b10101, lane_word(1, 16'hC1) | lane_word(3, 16'hC3) | lane_word(5, 16'hC5), 1'b0);
        cycle(1'b1, 5'b00011, lane_word(1, 16'hD1) | lane_word(2, 16'hD2), 1'b0);
        cycle(1'b0, 5'b0, '0, 1'b0);
        check("rst_clears_valid", 32'(bus.dout_valid), 32'h0);
        idle(4, 1'b1);
        check("no_stale_word", 32'(bus.dout_valid), 32'h0);

`ifdef COLLECTOR_STRICT_ORDER_EN
        // Lane 2 first must wait for lane 1.
        cycle(1'b0, 5'b0, '0, 1'b0);
        cycle(1'b1, 5'b00010, lane_word(2, 16'hE002), 1'b1);
        idle(3, 1'b1);
        check("strict_wait", 32'(bus.dout_valid), 32'h0);
        cycle(1'b1, 5'b00001, lane_word(1, 16'hE001), 1'b1);
        idle(1, 1'b1);
        check("strict_first", 32'(bus.dout_sel), 32'd0);
        idle(1, 1'b1);
        check("strict_second", 32'(bus.dout_sel), 32'd1);
`endif

        // Random traffic with occasional reset.
        for (int k = 0; k < 3000; k++) begin
            logic [5*DW-1:0] w;
            for (int i = 0; i < 5; i++) w[i*DW +: DW] = DW'($urandom);
            cycle(($urandom_range(0, 299) != 0), 5'($urandom), w, ($urandom_range(0, 3) != 0));
        end
        idle(12, 1'b1);

        // Every word accepted since the last reset is delivered, buffered or on the output.
        pending = m_ov ? 1 : 0;
        for (int i = 0; i < 5; i++) pending += m_full[i] ? 1 : 0;
        check("conservation", 32'(delivered + pending), 32'(accepted));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
